// File: rtl/vga_scanout.sv
// 640x480@60 scanout of the 512x256 mono framebuffer, centred with a black border.
// One screen row is burst-fetched into a 32-word line buffer during each h-blank.
module vga_scanout (
   input  logic        clk,
   input  logic        reset,
   input  logic        vram_loaded,
   input  logic [15:0] vram_data,
   output logic        vram_rden,
   output logic [13:0] vram_raddr,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pixel
);

   localparam int RD_LAT = 3;

   localparam logic [9:0] H_ACT  = 10'd640;
   localparam logic [9:0] H_LAST = 10'd799;
   localparam logic [9:0] HS_LO  = 10'd656;
   localparam logic [9:0] HS_HI  = 10'd751;
   localparam logic [9:0] V_ACT  = 10'd480;
   localparam logic [9:0] V_LAST = 10'd524;
   localparam logic [9:0] VS_LO  = 10'd490;
   localparam logic [9:0] VS_HI  = 10'd491;
   localparam logic [9:0] X_OFF  = 10'd64;
   localparam logic [9:0] X_END  = 10'd575;
   localparam logic [9:0] Y_OFF  = 10'd112;
   localparam logic [9:0] Y_END  = 10'd367;
   localparam logic [9:0] F_FST  = 10'd111;
   localparam logic [9:0] F_LST  = 10'd366;

   localparam logic [5:0] B_LAST = 6'(32 + RD_LAT - 2);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN
   } fetch_t;

   logic [9:0] h, v;

   fetch_t      state, state_nx;
   logic [5:0]  cnt, cnt_nx;
   logic [7:0]  row, row_nx;
   logic        rden_nx;
   logic [13:0] raddr_nx;
   logic        row_valid, valid_nx;

   logic [RD_LAT-1:0][5:0] tag;
   logic [5:0]             tag_out;
   logic                   push;

   logic [15:0] linebuf [32];

   logic        fetch_pt;
   logic [7:0]  fetch_row;
   logic [8:0]  col;
   logic [15:0] word;
   logic        hs_d, vs_d, de_d, px_d;
   logic        in_scr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   assign fetch_pt  = (h == H_ACT) && (v >= F_FST) && (v <= F_LST);
   assign fetch_row = 8'(v - F_FST);
   assign push      = vram_rden && !cnt[5];
   assign tag_out   = tag[RD_LAT-1];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = row;
      rden_nx  = vram_rden;
      raddr_nx = vram_raddr;
      valid_nx = row_valid;
      unique case (state)
         IDLE: begin
            if (fetch_pt) begin
               valid_nx = 1'b0;
               if (vram_loaded) begin
                  state_nx = BURST;
                  cnt_nx   = '0;
                  row_nx   = fetch_row;
                  rden_nx  = 1'b1;
                  raddr_nx = {1'b0, fetch_row, 5'd0};
               end
            end
         end
         BURST: begin
            if (cnt == B_LAST) begin
               state_nx = DRAIN;
               rden_nx  = 1'b0;
            end else begin
               cnt_nx   = cnt + 6'd1;
               // tail cycles repeat the last word's address
               raddr_nx = {1'b0, row,
                           cnt_nx[5] ? 5'd31 : cnt_nx[4:0]};
            end
         end
         DRAIN: begin
            if (tag_out[5] && tag_out[4:0] == 5'd31) begin
               state_nx = IDLE;
               valid_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         row        <= '0;
         vram_rden  <= 1'b0;
         vram_raddr <= '0;
         row_valid  <= 1'b0;
         tag        <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         row        <= row_nx;
         vram_rden  <= rden_nx;
         vram_raddr <= raddr_nx;
         row_valid  <= valid_nx;
         tag        <= {tag[RD_LAT-2:0], {push, cnt[4:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset && tag_out[5])
         linebuf[tag_out[4:0]] <= vram_data;
   end

   assign col    = 9'(h - X_OFF);
   assign word   = linebuf[col[8:4]];
   assign in_scr = (v >= Y_OFF) && (v <= Y_END) &&
                   (h >= X_OFF) && (h <= X_END);

   assign hs_d = !((h >= HS_LO) && (h <= HS_HI));
   assign vs_d = !((v >= VS_LO) && (v <= VS_HI));
   assign de_d = (h < H_ACT) && (v < V_ACT);
   assign px_d = in_scr && row_valid && !word[col[3:0]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         pixel <= 1'b0;
      end else begin
         hsync <= hs_d;
         vsync <= vs_d;
         de    <= de_d;
         pixel <= px_d;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a 3-cycle-latency VRAM model.
// Tracks scan position from reset and compares timing, fetches and pixels.
module tb_vga_scanout;

   logic        clk = 1'b0;
   logic        reset;
   logic        vram_loaded;
   logic [15:0] vram_data;
   logic        vram_rden;
   logic [13:0] vram_raddr;
   logic        hsync, vsync, de, pixel;

   always #5 clk = ~clk;

   vga_scanout dut (
      .clk        (clk),
      .reset      (reset),
      .vram_loaded(vram_loaded),
      .vram_data  (vram_data),
      .vram_rden  (vram_rden),
      .vram_raddr (vram_raddr),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .pixel      (pixel)
   );

   logic [15:0] mem [8192];
   logic [15:0] d1, d2;

   always @(posedge clk) begin
      d1        <= vram_rden ? mem[vram_raddr[12:0]] : 16'hDEAD;
      d2        <= d1;
      vram_data <= d2;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", tag, got, exp);
   endtask

   int cnt = 0;
   bit post_rst = 1'b1;
   bit ld_at [525];
   int seg = 0;
   int bad_hs, bad_vs, bad_de, bad_px, bad_rd, bad_ra;
   int n_hs, n_vs, n_de, n_rd;

   task automatic clr();
      bad_hs = 0; bad_vs = 0; bad_de = 0;
      bad_px = 0; bad_rd = 0; bad_ra = 0;
      n_hs = 0; n_vs = 0; n_de = 0; n_rd = 0;
   endtask

   task automatic directed(input int hc, input int vc,
                           input int hp, input int vp);
      if (vc == 111 && hc == 640) chk("rd_v111_pre", vram_rden, 0);
      if (vc == 111 && hc == 641) begin
         chk("rd_v111_start", vram_rden, 1);
         chk("ra_v111_h641", int'(vram_raddr), 0);
      end
      if (vc == 111 && hc == 672) chk("ra_v111_k31", int'(vram_raddr), 31);
      if (vc == 111 && hc == 674) begin
         chk("rd_v111_last", vram_rden, 1);
         chk("ra_v111_tail", int'(vram_raddr), 31);
      end
      if (vc == 111 && hc == 675) chk("rd_v111_end", vram_rden, 0);
      if (vc == 150 && hc == 641) chk("rd_unloaded", vram_rden, 0);
      if (vc == 366 && hc == 641) chk("ra_v366_first", int'(vram_raddr), 8160);
      if (vc == 366 && hc == 672) chk("ra_v366_k31", int'(vram_raddr), 8191);
      if (vc == 367 && hc == 641) chk("rd_v367_none", vram_rden, 0);
      if (vp == 112) begin
         if (hp == 63)  chk("px112_h63", pixel, 0);
         if (hp == 64)  chk("px112_h64", pixel, 0);
         if (hp == 65)  chk("px112_h65", pixel, 1);
         if (hp == 574) chk("px112_h574", pixel, 1);
         if (hp == 575) chk("px112_h575", pixel, 0);
         if (hp == 576) chk("px112_h576", pixel, 0);
      end
      if (vp == 151 && hp == 300) chk("px_invalid_row", pixel, 0);
      if (vp == 367) begin
         if (hp == 64)  chk("px367_h64", pixel, 1);
         if (hp == 65)  chk("px367_h65", pixel, 0);
         if (hp == 560) chk("px367_h560", pixel, 1);
         if (hp == 575) chk("px367_h575", pixel, 0);
      end
      if (vp == 5 && hp == 655) chk("hs_h655", hsync, 1);
      if (vp == 5 && hp == 656) chk("hs_h656", hsync, 0);
      if (vp == 5 && hp == 751) chk("hs_h751", hsync, 0);
      if (vp == 5 && hp == 752) chk("hs_h752", hsync, 1);
      if (vp == 489 && hp == 799) chk("vs_v489", vsync, 1);
      if (vp == 490 && hp == 0)   chk("vs_v490", vsync, 0);
      if (vp == 491 && hp == 799) chk("vs_v491", vsync, 0);
      if (vp == 492 && hp == 0)   chk("vs_v492", vsync, 1);
      if (vp == 0 && hp == 639)   chk("de_h639", de, 1);
      if (vp == 0 && hp == 640)   chk("de_h640", de, 0);
      if (vp == 479 && hp == 639) chk("de_v479", de, 1);
      if (vp == 480 && hp == 0)   chk("de_v480", de, 0);
   endtask

   task automatic observe();
      int hc, vc, p, hp, vp, k, e_ra;
      bit e_hs, e_vs, e_de, e_px, e_rd;
      logic [15:0] w;
      hc = cnt % 800;
      vc = (cnt / 800) % 525;
      if (hc == 640) ld_at[vc] = vram_loaded;
      if (post_rst) return;
      p  = cnt - 1;
      hp = p % 800;
      vp = (p / 800) % 525;
      e_hs = !(hp >= 656 && hp <= 751);
      e_vs = !(vp == 490 || vp == 491);
      e_de = (hp < 640) && (vp < 480);
      e_px = 1'b0;
      if (vp >= 112 && vp <= 367 && hp >= 64 && hp <= 575 &&
          ld_at[vp-1]) begin
         w    = mem[(vp - 112) * 32 + (hp - 64) / 16];
         e_px = !w[(hp - 64) % 16];
      end
      e_rd = vc >= 111 && vc <= 366 && hc >= 641 && hc <= 674 &&
             ld_at[vc];
      k    = (hc - 641 > 31) ? 31 : hc - 641;
      e_ra = (vc - 111) * 32 + k;
      bad_hs += int'(hsync !== e_hs);
      bad_vs += int'(vsync !== e_vs);
      bad_de += int'(de !== e_de);
      bad_px += int'(pixel !== e_px);
      bad_rd += int'(vram_rden !== e_rd);
      if (e_rd) bad_ra += int'(int'(vram_raddr) != e_ra);
      n_hs += int'(!hsync);
      n_vs += int'(!vsync);
      n_de += int'(de);
      n_rd += int'(vram_rden);
      if (seg == 3) directed(hc, vc, hp, vp);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         cnt = 0;
         post_rst = 1'b1;
      end else begin
         cnt++;
         post_rst = 1'b0;
      end
      @(negedge clk);
      observe();
   endtask

   task automatic chk_bad(input string s);
      chk({s, "_hsync"}, bad_hs, 0);
      chk({s, "_vsync"}, bad_vs, 0);
      chk({s, "_de"},    bad_de, 0);
      chk({s, "_pixel"}, bad_px, 0);
      chk({s, "_rden"},  bad_rd, 0);
      chk({s, "_raddr"}, bad_ra, 0);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++)
         mem[i] = 16'(i * 40503 + 12345) ^ 16'(i << 5);
      for (int j = 0; j < 32; j++) begin
         mem[j]           = 16'h0000;
         mem[39 * 32 + j] = 16'h0000;
         mem[8160 + j]    = 16'hFFFE;
      end
      mem[0]  = 16'h0001;
      mem[31] = 16'h8000;
      d1 = '0;
      d2 = '0;
      vram_data = '0;
      reset = 1'b0;
      vram_loaded = 1'b1;
      clr();

      repeat (3) tick();
      chk("rst_rden",  vram_rden, 0);
      chk("rst_raddr", int'(vram_raddr), 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_de",    de, 0);
      chk("rst_pixel", pixel, 0);

      // run to burst cycle 10 of the first fetch, then pulse reset
      seg = 1;
      reset = 1'b1;
      while (cnt != 111 * 800 + 651) tick();
      chk("seg1_burst10_rden", vram_rden, 1);
      chk("seg1_rden_cnt", n_rd, 11);
      chk_bad("seg1");
      reset = 1'b0;
      tick();
      chk("midrst_rden", vram_rden, 0);
      chk("midrst_raddr", int'(vram_raddr), 0);
      chk("midrst_de", de, 0);
      reset = 1'b1;
      tick();
      chk("midrst_first_de", de, 1);

      // one full frame with a gap in vram_loaded
      seg = 3;
      clr();
      repeat (419999) begin
         tick();
         if (cnt == 150 * 800) vram_loaded = 1'b0;
         if (cnt == 249 * 800 + 300) vram_loaded = 1'b1;
      end
      chk_bad("frame");
      chk("frame_hs_low", n_hs, 50400);
      chk("frame_vs_low", n_vs, 1600);
      chk("frame_de_high", n_de, 306560 + 640 - 1);
      chk("frame_rden_high", n_rd, 5338);

      seg = 4;
      clr();
      repeat (2001) tick();
      chk_bad("wrap");
      chk("wrap_de_high", n_de, 1681);
      chk("wrap_hs_low", n_hs, 192);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
